// File: rtl/hacd_pkg.sv
// Shared packet types between the CPU write-stall stage and the hawk
// override controller.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 48
`endif

package hacd_pkg;

  localparam int HACD_ADDR_WIDTH = `HACD_AXI4_ADDR_WIDTH;

  // Request held by the stall stage: a 4KB host page waiting for clearance.
  typedef struct packed {
    logic        valid;
    logic [47:0] hppa;
  } cpu_reqpkt_t;

  // Grant pulse back to the stall stage plus the translated page address.
  typedef struct packed {
    logic                       allow_access;
    logic [HACD_ADDR_WIDTH-1:0] ppa;
  } hawk_cpu_ovrd_pkt_t;

endpackage

// File: rtl/hawk_cpu_ovrd_ctrl.sv
// Hawk CPU override controller: translates the stalled host page through a
// small fully-associative cache, fetches missing mappings from the page
// engine, and issues a single grant pulse per stalled request.
module hawk_cpu_ovrd_ctrl
  import hacd_pkg::*;
#(
  parameter int ADDR_WIDTH  = hacd_pkg::HACD_ADDR_WIDTH,
  parameter int NUM_ENTRIES = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  cpu_reqpkt_t              cpu_reqpkt,
  output hawk_cpu_ovrd_pkt_t       hawk_cpu_ovrd_pkt,
  input  logic                     hawk_inactive,
  output logic                     miss_req_valid,
  input  logic                     miss_req_ready,
  output logic [47:0]              miss_req_hppa,
  input  logic                     fill_valid,
  input  logic [47:0]              fill_hppa,
  input  logic [ADDR_WIDTH-13:0]   fill_ppa,
  input  logic                     inv_valid,
  input  logic [47:0]              inv_hppa,
  output logic [CNT_WIDTH-1:0]     hit_count,
  output logic [CNT_WIDTH-1:0]     miss_count
);

  localparam int PAGE_W = ADDR_WIDTH - 12;
  localparam int IDX_W  = $clog2(NUM_ENTRIES);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    GRANT,
    DRAIN
  } state_t;

  state_t                  state;
  logic [47:0]             req_hppa_q;
  logic                    allow_q;
  logic [ADDR_WIDTH-1:0]   ppa_q;

  // Translation cache storage
  logic [NUM_ENTRIES-1:0]  ent_valid;
  logic [47:0]             ent_hppa [NUM_ENTRIES];
  logic [PAGE_W-1:0]       ent_ppa  [NUM_ENTRIES];
  idx_t                    rr_ptr;

  // Lookup and fill-placement results
  logic                    lkp_hit;
  logic [PAGE_W-1:0]       lkp_ppa;
  logic                    fill_match;
  idx_t                    fill_match_idx;
  logic                    free_found;
  idx_t                    free_idx;
  idx_t                    fill_idx;
  logic                    fill_use_rr;
  logic                    fill_write;
  logic                    fill_hit;

  // Compare the captured request against every valid entry; lowest index wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch to hold it.
    lkp_hit = 1'b0;
    lkp_ppa = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      // NOTE: combinational logic uses blocking '=' so later statements see
      // the updated value; clocked state below uses non-blocking '<='.
      if (!lkp_hit && ent_valid[i] && (ent_hppa[i] == req_hppa_q)) begin
        lkp_hit = 1'b1;
        lkp_ppa = ent_ppa[i];
      end
    end
  end

  // Choose where an incoming fill lands: existing entry, free slot, or victim.
  always_comb begin
    fill_match     = 1'b0;
    fill_match_idx = '0;
    free_found     = 1'b0;
    free_idx       = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!fill_match && ent_valid[i] && (ent_hppa[i] == fill_hppa)) begin
        fill_match     = 1'b1;
        fill_match_idx = idx_t'(i);
      end
      if (!free_found && !ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = idx_t'(i);
      end
    end
    fill_use_rr = !fill_match && !free_found;
    fill_idx    = fill_match ? fill_match_idx : (free_found ? free_idx : rr_ptr);
    // An invalidate of the same page in the same cycle wins over the fill.
    fill_write  = fill_valid && !(inv_valid && (inv_hppa == fill_hppa));
    fill_hit    = fill_valid && (fill_hppa == req_hppa_q);
  end

  // Entry valid bits and replacement pointer; invalidates first, fill last.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (inv_valid && ent_valid[i] && (ent_hppa[i] == inv_hppa)) begin
          ent_valid[i] <= 1'b0;
        end
      end
      if (fill_write) begin
        ent_valid[fill_idx] <= 1'b1;
        if (fill_use_rr) begin
          rr_ptr <= (rr_ptr == idx_t'(NUM_ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
        end
      end
    end
  end

  // Entry payload writes on installation.
  always_ff @(posedge clk) begin
    // NOTE: the payload array is deliberately left unreset; the valid bits
    // gate every use of it, so resetting it would only cost flop resets.
    if (fill_write) begin
      ent_hppa[fill_idx] <= fill_hppa;
      ent_ppa[fill_idx]  <= fill_ppa;
    end
  end

  // Request FSM with registered grant, miss request and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_hppa_q     <= '0;
      allow_q        <= 1'b0;
      ppa_q          <= '0;
      miss_req_valid <= 1'b0;
      miss_req_hppa  <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      allow_q <= 1'b0;
      if ((state != IDLE) && hawk_inactive) begin
        state          <= IDLE;
        miss_req_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cpu_reqpkt.valid && !hawk_inactive) begin
              req_hppa_q <= cpu_reqpkt.hppa;
              state      <= LOOKUP;
            end
          end
          LOOKUP: begin
            if (lkp_hit) begin
              ppa_q   <= {lkp_ppa, 12'h0};
              allow_q <= 1'b1;
              state   <= GRANT;
              if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
              miss_req_valid <= 1'b1;
              miss_req_hppa  <= req_hppa_q;
              state          <= MISS_REQ;
              if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
          end
          MISS_REQ: begin
            if (fill_hit) begin
              miss_req_valid <= 1'b0;
              ppa_q          <= {fill_ppa, 12'h0};
              allow_q        <= 1'b1;
              state          <= GRANT;
            end else if (miss_req_ready) begin
              miss_req_valid <= 1'b0;
              state          <= MISS_WAIT;
            end
          end
          MISS_WAIT: begin
            if (fill_hit) begin
              ppa_q   <= {fill_ppa, 12'h0};
              allow_q <= 1'b1;
              state   <= GRANT;
            end
          end
          GRANT: begin
            state <= DRAIN;
          end
          DRAIN: begin
            if (!cpu_reqpkt.valid) state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign hawk_cpu_ovrd_pkt = '{allow_access: allow_q, ppa: ppa_q};

endmodule

// File: tb/tb_hawk_cpu_ovrd_ctrl.sv
// Self-checking bench for hawk_cpu_ovrd_ctrl: directed scenarios plus a
// randomized request stream against a page-map reference model.
module tb_hawk_cpu_ovrd_ctrl;
  import hacd_pkg::*;

  localparam int AW = HACD_ADDR_WIDTH;
  localparam int PW = AW - 12;
  localparam int N  = 8;
  localparam int CW = 32;

  logic               clk = 1'b0;
  logic               rst;
  cpu_reqpkt_t        cpu_reqpkt;
  hawk_cpu_ovrd_pkt_t ovrd;
  logic               hawk_inactive;
  logic               miss_req_valid;
  logic               miss_req_ready;
  logic [47:0]        miss_req_hppa;
  logic               fill_valid;
  logic [47:0]        fill_hppa;
  logic [PW-1:0]      fill_ppa;
  logic               inv_valid;
  logic [47:0]        inv_hppa;
  logic [CW-1:0]      hit_count;
  logic [CW-1:0]      miss_count;

  int checks = 0;
  int errors = 0;

  // Reference model: a table of (page -> physical page) with a victim pointer.
  typedef struct packed {
    logic          v;
    logic [47:0]   h;
    logic [PW-1:0] p;
  } m_ent_t;

  m_ent_t      m_cache [N];
  int          m_rr;
  int unsigned m_hits;
  int unsigned m_misses;

  hawk_cpu_ovrd_ctrl #(
    .ADDR_WIDTH (AW),
    .NUM_ENTRIES(N),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_reqpkt       (cpu_reqpkt),
    .hawk_cpu_ovrd_pkt(ovrd),
    .hawk_inactive    (hawk_inactive),
    .miss_req_valid   (miss_req_valid),
    .miss_req_ready   (miss_req_ready),
    .miss_req_hppa    (miss_req_hppa),
    .fill_valid       (fill_valid),
    .fill_hppa        (fill_hppa),
    .fill_ppa         (fill_ppa),
    .inv_valid        (inv_valid),
    .inv_hppa         (inv_hppa),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m_cache[i] = '0;
    m_rr     = 0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic bit model_lookup(input logic [47:0] h, output logic [PW-1:0] p);
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (m_cache[i].v && m_cache[i].h == h) begin
        p = m_cache[i].p;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One cycle of fill/invalidate traffic as the cache should see it.
  function automatic void model_apply(input bit fv, input logic [47:0] fh, input logic [PW-1:0] fp,
                                      input bit iv, input logic [47:0] ih);
    int tgt = -1;
    if (fv && !(iv && ih == fh)) begin
      for (int i = 0; i < N; i++) if (tgt < 0 && m_cache[i].v && m_cache[i].h == fh) tgt = i;
      for (int i = 0; i < N; i++) if (tgt < 0 && !m_cache[i].v) tgt = i;
      if (tgt < 0) begin
        tgt  = m_rr;
        m_rr = (m_rr + 1) % N;
      end
    end
    if (iv) for (int i = 0; i < N; i++) if (m_cache[i].v && m_cache[i].h == ih) m_cache[i].v = 1'b0;
    if (tgt >= 0) m_cache[tgt] = '{v: 1'b1, h: fh, p: fp};
  endfunction

  task automatic cycle_op(input bit fv, input logic [47:0] fh, input logic [PW-1:0] fp,
                          input bit iv, input logic [47:0] ih);
    fill_valid = fv;
    fill_hppa  = fh;
    fill_ppa   = fp;
    inv_valid  = iv;
    inv_hppa   = ih;
    model_apply(fv, fh, fp, iv, ih);
    step();
    fill_valid = 1'b0;
    inv_valid  = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic check_counters(input string tag);
    checks++;
    if (hit_count !== CW'(m_hits) || miss_count !== CW'(m_misses)) begin
      errors++;
      $display("FAIL %s counters: hit=%0d miss=%0d, required hit=%0d miss=%0d",
               tag, hit_count, miss_count, m_hits, m_misses);
    end
  endtask

  // Full request from IDLE to IDLE; the model decides hit or miss.
  task automatic do_request(input logic [47:0] h, input int rd, input int fd,
                            input bit early, input logic [PW-1:0] fp);
    logic [PW-1:0] mp;
    logic [AW-1:0] exp_ppa;
    bit            exp_hit;
    exp_hit = model_lookup(h, mp);
    cpu_reqpkt.valid = 1'b1;
    cpu_reqpkt.hppa  = h;
    step();
    checks++;
    if (ovrd.allow_access !== 1'b0 || miss_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL req_lookup_quiet page=%h: allow=%b miss_req=%b, required 0 0",
               h, ovrd.allow_access, miss_req_valid);
    end
    step();
    checks++;
    if (ovrd.allow_access !== exp_hit || miss_req_valid !== !exp_hit) begin
      errors++;
      $display("FAIL req_hit_or_miss page=%h: allow=%b miss_req=%b, required %b %b",
               h, ovrd.allow_access, miss_req_valid, exp_hit, !exp_hit);
    end
    if (exp_hit) begin
      m_hits++;
      exp_ppa = {mp, 12'h0};
      checks++;
      if (ovrd.ppa !== exp_ppa) begin
        errors++;
        $display("FAIL hit_ppa page=%h: ppa=%h, required %h", h, ovrd.ppa, exp_ppa);
      end
    end else begin
      m_misses++;
      checks++;
      if (miss_req_hppa !== h) begin
        errors++;
        $display("FAIL miss_req_hppa: got %h, required %h", miss_req_hppa, h);
      end
      for (int c = 0; c < rd; c++) begin
        step();
        checks++;
        if (miss_req_valid !== 1'b1 || miss_req_hppa !== h || ovrd.allow_access !== 1'b0) begin
          errors++;
          $display("FAIL miss_req_hold cycle %0d: valid=%b hppa=%h allow=%b, required 1 %h 0",
                   c, miss_req_valid, miss_req_hppa, ovrd.allow_access, h);
        end
      end
      if (!early) begin
        miss_req_ready = 1'b1;
        step();
        miss_req_ready = 1'b0;
        checks++;
        if (miss_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL miss_req_drop: valid=%b, required 0", miss_req_valid);
        end
        for (int c = 0; c < fd; c++) begin
          step();
          checks++;
          if (ovrd.allow_access !== 1'b0) begin
            errors++;
            $display("FAIL miss_wait_quiet cycle %0d: allow=%b, required 0", c, ovrd.allow_access);
          end
        end
      end
      cycle_op(1'b1, h, fp, 1'b0, '0);
      exp_ppa = {fp, 12'h0};
      checks++;
      if (ovrd.allow_access !== 1'b1 || ovrd.ppa !== exp_ppa || miss_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL miss_grant page=%h: allow=%b ppa=%h miss_req=%b, required 1 %h 0",
                 h, ovrd.allow_access, ovrd.ppa, miss_req_valid, exp_ppa);
      end
    end
    step();
    checks++;
    if (ovrd.allow_access !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse page=%h: allow=%b, required 0", h, ovrd.allow_access);
    end
    cpu_reqpkt.valid = 1'b0;
    step();
    step();
    check_counters("request");
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (ovrd.allow_access !== 1'b0 || ovrd.ppa !== '0 || miss_req_valid !== 1'b0 ||
        miss_req_hppa !== '0 || hit_count !== '0 || miss_count !== '0) begin
      errors++;
      $display("FAIL reset_values: allow=%b ppa=%h mrv=%b mrh=%h hit=%0d miss=%0d, required all 0",
               ovrd.allow_access, ovrd.ppa, miss_req_valid, miss_req_hppa, hit_count, miss_count);
    end
  endtask

  task automatic test_miss_then_hit();
    apply_reset();
    cycle_op(1'b1, 48'hABC, PW'(36'h0001234), 1'b0, '0);
    do_request(48'hABC, 0, 0, 1'b0, '0);
  endtask

  task automatic test_miss_path();
    apply_reset();
    do_request(48'h55, 3, 5, 1'b0, PW'(36'h77));
  endtask

  task automatic test_drain();
    int pulses = 0;
    apply_reset();
    cycle_op(1'b1, 48'h60, PW'(36'h61), 1'b0, '0);
    cpu_reqpkt.valid = 1'b1;
    cpu_reqpkt.hppa  = 48'h60;
    step();
    step();
    m_hits++;
    checks++;
    if (ovrd.allow_access !== 1'b1) begin
      errors++;
      $display("FAIL drain_first_grant: allow=%b, required 1", ovrd.allow_access);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      if (ovrd.allow_access === 1'b1 || miss_req_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL drain_no_regrant: extra activity cycles=%0d, required 0", pulses);
    end
    cpu_reqpkt.valid = 1'b0;
    step();
    do_request(48'h60, 0, 0, 1'b0, '0);
  endtask

  task automatic test_replacement();
    apply_reset();
    for (int i = 0; i < 9; i++) cycle_op(1'b1, 48'h10 + 48'(i), PW'(36'h200 + 36'(i)), 1'b0, '0);
    do_request(48'h10, 1, 1, 1'b0, PW'(36'h310));
    do_request(48'h18, 0, 0, 1'b0, '0);
    do_request(48'h11, 0, 0, 1'b1, PW'(36'h311));
  endtask

  task automatic test_race();
    apply_reset();
    cycle_op(1'b1, 48'h20, PW'(36'h5), 1'b1, 48'h20);
    do_request(48'h20, 0, 2, 1'b0, PW'(36'h21));
    cycle_op(1'b1, 48'h99, PW'(36'h9), 1'b1, 48'h20);
    do_request(48'h99, 0, 0, 1'b0, '0);
    do_request(48'h20, 2, 0, 1'b1, PW'(36'h22));
  endtask

  task automatic test_abort();
    apply_reset();
    hawk_inactive    = 1'b1;
    cpu_reqpkt.valid = 1'b1;
    cpu_reqpkt.hppa  = 48'h40;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (ovrd.allow_access !== 1'b0 || miss_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL inactive_idle_quiet: allow=%b miss_req=%b, required 0 0",
                 ovrd.allow_access, miss_req_valid);
      end
    end
    hawk_inactive = 1'b0;
    step();
    step();
    m_misses++;
    checks++;
    if (miss_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup_miss: miss_req=%b, required 1", miss_req_valid);
    end
    hawk_inactive = 1'b1;
    step();
    checks++;
    if (miss_req_valid !== 1'b0 || ovrd.allow_access !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: miss_req=%b allow=%b, required 0 0", miss_req_valid, ovrd.allow_access);
    end
    cpu_reqpkt.valid = 1'b0;
    step();
    hawk_inactive = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (ovrd.allow_access !== 1'b0 || miss_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: allow=%b miss_req=%b, required 0 0", ovrd.allow_access, miss_req_valid);
      end
    end
    check_counters("abort");
    do_request(48'h40, 1, 0, 1'b0, PW'(36'h41));
  endtask

  task automatic test_reset_midway();
    apply_reset();
    cpu_reqpkt.valid = 1'b1;
    cpu_reqpkt.hppa  = 48'h66;
    step();
    step();
    miss_req_ready = 1'b1;
    step();
    miss_req_ready   = 1'b0;
    rst              = 1'b1;
    cpu_reqpkt.valid = 1'b0;
    step();
    rst = 1'b0;
    model_clear();
    cycle_op(1'b1, 48'h66, PW'(36'h67), 1'b0, '0);
    checks++;
    if (ovrd.allow_access !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_grant_fill: allow=%b, required 0", ovrd.allow_access);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (ovrd.allow_access !== 1'b0 || miss_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_grant: allow=%b miss_req=%b, required 0 0", ovrd.allow_access, miss_req_valid);
      end
    end
    check_counters("reset_midway");
  endtask

  task automatic test_random();
    logic [47:0]   pg;
    logic [47:0]   bg_f;
    logic [47:0]   bg_i;
    logic [PW-1:0] rp;
    apply_reset();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        bg_f = 48'h100 + 48'($urandom_range(0, 11));
        bg_i = 48'h100 + 48'($urandom_range(0, 11));
        rp   = PW'({$urandom(), $urandom()});
        cycle_op(1'($urandom_range(0, 1)), bg_f, rp, 1'($urandom_range(0, 1)), bg_i);
      end
      pg = 48'h100 + 48'($urandom_range(0, 11));
      rp = PW'({$urandom(), $urandom()});
      do_request(pg, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), rp);
    end
  endtask

  initial begin
    rst              = 1'b1;
    cpu_reqpkt       = '0;
    hawk_inactive    = 1'b0;
    miss_req_ready   = 1'b0;
    fill_valid       = 1'b0;
    fill_hppa        = '0;
    fill_ppa         = '0;
    inv_valid        = 1'b0;
    inv_hppa         = '0;
    model_clear();
    test_reset();
    test_miss_then_hit();
    test_miss_path();
    test_drain();
    test_replacement();
    test_race();
    test_abort();
    test_reset_midway();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
